route_arbiter: RTL and testbench

ROUTE_ARBITER -- requirements
Module: route_arbiter

---
 rtl/router_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/route_arbiter.sv | 80 ++++++++
 tb/tb_route_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: default channel count and flit width, the flit
// type, and a round-robin index helper used by the arbitration stages.
package router_pkg;

  localparam int NUM_IN_DEFAULT = 4;
  localparam int FLIT_W_DEFAULT = 11;

  typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

  // Next channel index in a ring of n channels.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection over NUM_IN requests; the pointer remembers the
// last granted channel and only moves when the caller reports a transfer.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEFAULT,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic              grant_vld,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Search begins one past the last winner, so the last winner has lowest priority.
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr_q;
    cand_idx  = ptr_q;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_idx = IDX_W'(rr_next(int'(cand_idx), NUM_IN));
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
    grant_vld = found;
    ptr_d     = advance ? grant_idx : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IDX_W'(NUM_IN - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/route_arbiter.sv
// Merges NUM_IN valid/ready flit channels into one registered output stage
// using round-robin arbitration; supports drain and reload in the same cycle.
module route_arbiter
  import router_pkg::*;
#(
  parameter  int NUM_IN = NUM_IN_DEFAULT,
  parameter  int FLIT_W = FLIT_W_DEFAULT,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLIT_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_src
);

  // Handshake: a flit moves on any port only when valid and ready are both
  // high at the rising edge; valid never waits on ready, and in_ready is a
  // function of in_valid, the pointer and the output stage only (never data).

  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic              load_en;

  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0]  out_src_q,   out_src_d;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (load_en),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  always_comb begin
    load_en  = !rst && grant_vld && (!out_valid_q || out_ready);
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = load_en && (grant_idx == IDX_W'(i));
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*FLIT_W +: FLIT_W];
      out_src_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_route_arbiter.sv
// Self-checking bench for route_arbiter: directed scenarios plus a randomized
// run checked against a round-robin reference model and a flit scoreboard.
module tb_route_arbiter;

  localparam int NUM_IN = 4;
  localparam int FLIT_W = 11;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*FLIT_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [FLIT_W-1:0]        out_data;
  logic [1:0]               out_src;

  route_arbiter #(
    .NUM_IN (NUM_IN),
    .FLIT_W (FLIT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: last-granted channel, held output flit, and the queue of
  // accepted flits ({src, data}) still owed downstream.
  int                 m_ptr;
  bit                 m_ov;
  logic [FLIT_W-1:0]  m_od;
  int                 m_os;
  logic [FLIT_W+1:0]  exp_q[$];

  function automatic logic [NUM_IN*FLIT_W-1:0] pack4(input logic [FLIT_W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic int model_grant(input logic [NUM_IN-1:0] v);
    for (int k = 1; k <= NUM_IN; k++) begin
      int c;
      c = (m_ptr + k) % NUM_IN;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NUM_IN-1:0] model_ready(input logic [NUM_IN-1:0] v, input logic r);
    int g;
    g = model_grant(v);
    if (g >= 0 && (!m_ov || r)) return NUM_IN'(1 << g);
    return '0;
  endfunction

  task automatic model_reset();
    m_ptr = NUM_IN - 1;
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = 0;
    exp_q.delete();
  endtask

  // Driver tasks: inputs change just after the falling edge; checks happen
  // 1ns later, mid low phase; tick advances DUT and model across one edge.
  task automatic drive(input logic [NUM_IN-1:0] v, input logic [NUM_IN*FLIT_W-1:0] d,
                       input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      g = model_grant(in_valid);
      if (g >= 0 && (!m_ov || out_ready)) begin
        m_ptr = g;
        m_ov  = 1'b1;
        m_od  = in_data[g*FLIT_W +: FLIT_W];
        m_os  = g;
        exp_q.push_back({2'(g), m_od});
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [FLIT_W-1:0] chd [NUM_IN];

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = pack4(chd[0], chd[1], chd[2], chd[3]);
    out_ready = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 11'h000 || out_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h src=%0d required 0/000/0",
               out_valid, out_data, out_src);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b required 0000", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: in_ready=%b out_valid=%b required 0000/0", in_ready, out_valid);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [NUM_IN-1:0] exp_r;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'hF, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b1);
      exp_r = NUM_IN'(1 << (k % NUM_IN));
      if (k < 5) begin
        checks++;
        if (in_ready !== exp_r) begin
          errors++;
          $display("FAIL rr_grant[%0d]: in_ready=%b required %b", k, in_ready, exp_r);
        end
      end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'((k - 1) % NUM_IN) ||
            out_data !== chd[(k - 1) % NUM_IN]) begin
          errors++;
          $display("FAIL rr_out[%0d]: valid=%b src=%0d data=%h required 1/%0d/%h", k,
                   out_valid, out_src, out_data, (k - 1) % NUM_IN, chd[(k - 1) % NUM_IN]);
        end
      end
      tick();
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0100, pack4(11'h000, 11'h000, 11'h4A4, 11'h000), 1'b1);
      checks++;
      if (in_ready !== 4'b0100) begin
        errors++;
        $display("FAIL single_ready[%0d]: in_ready=%b required 0100", k, in_ready);
      end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 11'h4A4) begin
          errors++;
          $display("FAIL single_out[%0d]: valid=%b src=%0d data=%h required 1/2/4a4", k,
                   out_valid, out_src, out_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    drive(4'b0001, pack4(11'h067, 11'h000, 11'h000, 11'h000), 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 11'h067 || out_src !== 2'd0 ||
          in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b data=%h src=%0d in_ready=%b required 1/067/0/0000",
                 k, out_valid, out_data, out_src, in_ready);
      end
      tick();
    end
    drive(4'hF, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b1);
    checks++;
    if (in_ready !== 4'b0010 || out_data !== 11'h067) begin
      errors++;
      $display("FAIL release: in_ready=%b data=%h required 0010/067", in_ready, out_data);
    end
    tick();
    drive(4'h0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== chd[1]) begin
      errors++;
      $display("FAIL after_release: valid=%b src=%0d data=%h required 1/1/%h",
               out_valid, out_src, out_data, chd[1]);
    end
    tick();
    drive(4'h0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL drain_idle: valid=%b in_ready=%b required 0/0000", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_priority_order();
    do_reset();
    drive(4'b0010, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b1);
    tick();
    drive(4'b1010, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b1);
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL order_first: in_ready=%b required 1000", in_ready);
    end
    tick();
    drive(4'b1010, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b1);
    checks++;
    if (in_ready !== 4'b0010 || out_src !== 2'd3) begin
      errors++;
      $display("FAIL order_second: in_ready=%b src=%0d required 0010/3", in_ready, out_src);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0100, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b0);
    tick();
    drive(4'hF, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd2) begin
      errors++;
      $display("FAIL mid_loaded: valid=%b src=%0d required 1/2", out_valid, out_src);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 11'h000 || out_src !== 2'd0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h src=%0d in_ready=%b required 0/000/0/0000",
               out_valid, out_data, out_src, in_ready);
    end
    tick();
    rst = 1'b0;
    drive(4'hF, pack4(chd[0], chd[1], chd[2], chd[3]), 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_next_grant: in_ready=%b required 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [NUM_IN-1:0]        v;
    logic [NUM_IN*FLIT_W-1:0] d;
    logic                     r;
    logic [NUM_IN-1:0]        exp_r;
    logic [FLIT_W+1:0]        got;
    logic [FLIT_W+1:0]        want;
    int                       drain_cycles;
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      v = NUM_IN'($urandom_range(0, 15));
      d = (NUM_IN*FLIT_W)'({$urandom(), $urandom()});
      r = ($urandom_range(0, 3) != 0);
      drive(v, d, r);
      exp_r = model_ready(v, r);
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL rand_ready[%0d]: in_ready=%b required %b", n, in_ready, exp_r);
      end
      checks++;
      if (out_valid !== m_ov) begin
        errors++;
        $display("FAIL rand_valid[%0d]: out_valid=%b required %b", n, out_valid, m_ov);
      end
      if (out_valid === 1'b1 && r) begin
        checks++;
        got = {out_src, out_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra[%0d]: emitted %h with nothing accepted", n, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL rand_flit[%0d]: src/data=%h required %h", n, got, want);
          end
        end
      end
      tick();
    end
    drain_cycles = 0;
    while (exp_q.size() > 0 && drain_cycles < 20) begin
      drive('0, '0, 1'b1);
      if (out_valid === 1'b1) begin
        checks++;
        got  = {out_src, out_data};
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL drain_flit: src/data=%h required %h", got, want);
        end
      end
      tick();
      drain_cycles++;
    end
    drive('0, '0, 1'b1);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: pending=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    chd[0] = 11'h101;
    chd[1] = 11'h252;
    chd[2] = 11'h3A3;
    chd[3] = 11'h7F4;
    test_reset();
    test_round_robin();
    test_single_channel();
    test_back_pressure();
    test_priority_order();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
